// File: rtl/cache_refill_unit_pkg.sv
// Shared definitions for the cache refill unit and the cached data memory:
// address widths, FSM state encodings and the line-base address helper.
package cache_refill_unit_pkg;

  localparam int ADDR_W  = 14;
  localparam int WADDR_W = 10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WB   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_LAST = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Byte address -> first word of its line; both the subtraction and the
  // truncation to the RAM word space wrap silently.
  function automatic logic [WADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base_addr,
    input int                offset_bits
  );
    logic [ADDR_W-1:0]  diff;
    logic [WADDR_W-1:0] word;
    diff = addr - base_addr;
    word = diff[WADDR_W+1:2];
    return (word >> offset_bits) << offset_bits;
  endfunction

endpackage

// File: rtl/cache_refill_unit.sv
// Cache line refill engine: optional write-back of the victim line, then a
// line fetch from block RAM. Define REFILL_STATS_EN to add fill/wb counters.
module cache_refill_unit
  import cache_refill_unit_pkg::*;
#(
  parameter int                LINE_WORDS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 14'h1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wb,
  input  logic [ADDR_W-1:0]       req_wb_addr,
  input  logic [32*LINE_WORDS-1:0] req_wb_data,
  input  logic [ADDR_W-1:0]       req_fill_addr,
  output logic                    resp_valid,
  output logic [32*LINE_WORDS-1:0] resp_data,
  output logic [WADDR_W-1:0]      mem_addr,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    busy
`ifdef REFILL_STATS_EN
  ,
  output logic [15:0]             stat_fills,
  output logic [15:0]             stat_wbs
`endif
);

  localparam int             KW        = $clog2(LINE_WORDS);
  localparam int             LINE_BITS = 32 * LINE_WORDS;
  localparam logic [KW-1:0]  K_LAST    = KW'(LINE_WORDS - 1);

  logic [2:0]           state;
  logic [KW-1:0]        k;
  logic [WADDR_W-1:0]   wb_base;
  logic [WADDR_W-1:0]   fill_base;
  logic [LINE_BITS-1:0] wb_line;
  logic [LINE_BITS-1:0] line;
  logic [WADDR_W-1:0]   k_ext;

  assign k_ext = WADDR_W'(k);

  // RAM data lags mem_re by one cycle, so RD stores word k-1 and LAST
  // picks up the final word after the read strobe has dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      wb_base   <= '0;
      fill_base <= '0;
      wb_line   <= '0;
      line      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wb_base   <= line_base(req_wb_addr, BASE_ADDR, KW);
            fill_base <= line_base(req_fill_addr, BASE_ADDR, KW);
            wb_line   <= req_wb_data;
            k         <= '0;
            state     <= req_wb ? ST_WB : ST_RD;
          end
        end
        ST_WB: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= ST_RD;
        end
        ST_RD: begin
          if (k != '0) line[{k - 1'b1, 5'b0} +: 32] <= mem_rdata;
          k <= k + 1'b1;
          if (k == K_LAST) state <= ST_LAST;
        end
        ST_LAST: begin
          line[LINE_BITS-32 +: 32] <= mem_rdata;
          state                    <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_WB: begin
        mem_we    = 1'b1;
        mem_addr  = wb_base + k_ext;
        mem_wdata = wb_line[{k, 5'b0} +: 32];
      end
      ST_RD: begin
        mem_re   = 1'b1;
        mem_addr = fill_base + k_ext;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_data  = line;

`ifdef REFILL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fills <= '0;
      stat_wbs   <= '0;
    end else begin
      if (state == ST_RESP && stat_fills != 16'hFFFF)
        stat_fills <= stat_fills + 16'd1;
      if (state == ST_WB && k == K_LAST && stat_wbs != 16'hFFFF)
        stat_wbs <= stat_wbs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit with a behavioural block RAM;
// stat counters are also checked when REFILL_STATS_EN is defined.
module tb_cache_refill_unit;

  localparam int LW = 4;
  localparam int LB = 32 * LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wb = 1'b0;
  logic [13:0]   req_wb_addr = '0;
  logic [LB-1:0] req_wb_data = '0;
  logic [13:0]   req_fill_addr = '0;
  logic          resp_valid;
  logic [LB-1:0] resp_data;
  logic [9:0]    mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
`ifdef REFILL_STATS_EN
  logic [15:0]   stat_fills;
  logic [15:0]   stat_wbs;
`endif

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  cache_refill_unit #(.LINE_WORDS(LW), .BASE_ADDR(14'h1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef REFILL_STATS_EN
    , .stat_fills(stat_fills), .stat_wbs(stat_wbs)
`endif
  );

  // Synchronous block RAM: write on mem_we, registered read data after mem_re.
  logic [31:0] ram [1024];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  typedef struct {
    string         name;
    logic          wb;
    logic [13:0]   wb_addr;
    logic [LB-1:0] wb_line;
    logic [13:0]   fill_addr;
    logic [9:0]    wr_base;
    logic [9:0]    rd_base;
    int            lat;
    logic [LB-1:0] exp_data;
    logic          intrude;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string what, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat = 0;
    int pulses = 0;
    int overlap = 0;
    int ready_busy = 0;
    logic [LB-1:0] data_at_resp = '0;
    logic [9:0]  rd_a[$];
    logic [9:0]  wr_a[$];
    logic [31:0] wr_d[$];
    @(negedge clk);
    checkOutput({v.name, " ready_before"}, LB'(req_ready), LB'(1));
    req_valid     = 1'b1;
    req_wb        = v.wb;
    req_wb_addr   = v.wb_addr;
    req_wb_data   = v.wb_line;
    req_fill_addr = v.fill_addr;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (v.intrude && (c == 2 || c == 3)) begin
        req_valid     = 1'b1;
        req_wb        = 1'b0;
        req_wb_addr   = 14'h2000;
        req_fill_addr = 14'h1010;
      end
      if (mem_we) begin
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_wdata);
      end
      if (mem_re) rd_a.push_back(mem_addr);
      if (mem_we && mem_re) overlap++;
      if (resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          data_at_resp = resp_data;
        end
      end
      if (c <= v.lat && req_ready) ready_busy++;
    end
    checkOutput({v.name, " latency"}, LB'(lat), LB'(v.lat));
    checkOutput({v.name, " resp_pulses"}, LB'(pulses), LB'(1));
    checkOutput({v.name, " resp_data"}, data_at_resp, v.exp_data);
    checkOutput({v.name, " resp_data_held"}, resp_data, v.exp_data);
    checkOutput({v.name, " busy_after"}, LB'(busy), LB'(0));
    checkOutput({v.name, " we_re_overlap"}, LB'(overlap), LB'(0));
    checkOutput({v.name, " ready_while_busy"}, LB'(ready_busy), LB'(0));
    checkOutput({v.name, " rd_count"}, LB'(rd_a.size()), LB'(LW));
    for (int i = 0; i < LW; i++)
      if (i < rd_a.size())
        checkOutput($sformatf("%s rd_addr%0d", v.name, i), LB'(rd_a[i]), LB'(10'(v.rd_base + i)));
    checkOutput({v.name, " wr_count"}, LB'(wr_a.size()), LB'(v.wb ? LW : 0));
    for (int i = 0; i < LW; i++)
      if (i < wr_a.size()) begin
        checkOutput($sformatf("%s wr_addr%0d", v.name, i), LB'(wr_a[i]), LB'(10'(v.wr_base + i)));
        checkOutput($sformatf("%s wr_data%0d", v.name, i), LB'(wr_d[i]), LB'(v.wb_line[32*i +: 32]));
      end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    for (int i = 0; i < 4; i++) begin
      ram[4 + i]     <= 32'hA + 32'(i);
      ram[i]         <= 32'h100 + 32'(i);
      ram[1020 + i]  <= 32'h51 + 32'(i);
      ram[32 + i]    <= 32'hEEEE;
    end

    vecs[0] = '{"fill_only", 1'b0, 14'h0000, '0, 14'h1010, 10'd0, 10'd4, 6,
                {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0};
    vecs[1] = '{"wb_fill", 1'b1, 14'h1020, {32'h4, 32'h3, 32'h2, 32'h1}, 14'h1000, 10'd8, 10'd0, 10,
                {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0};
    vecs[2] = '{"same_line", 1'b1, 14'h1040, {32'h44, 32'h33, 32'h22, 32'h11}, 14'h1048, 10'd16, 10'd16, 10,
                {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0};
    vecs[3] = '{"addr_wrap", 1'b0, 14'h0000, '0, 14'h0FFE, 10'd0, 10'h3FC, 6,
                {32'h54, 32'h53, 32'h52, 32'h51}, 1'b0};
    vecs[4] = '{"alias_trunc", 1'b1, 14'h3000, {32'h8, 32'h7, 32'h6, 32'h5}, 14'h100C, 10'd0, 10'd0, 10,
                {32'h8, 32'h7, 32'h6, 32'h5}, 1'b0};
    vecs[5] = '{"wb_wrap", 1'b1, 14'h0FF0, {32'h64, 32'h63, 32'h62, 32'h61}, 14'h1014, 10'h3FC, 10'd4, 10,
                {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0};
    vecs[6] = '{"busy_ignore", 1'b1, 14'h1100, {32'h74, 32'h73, 32'h72, 32'h71}, 14'h1004, 10'd64, 10'd0, 10,
                {32'h8, 32'h7, 32'h6, 32'h5}, 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", LB'(req_ready), LB'(1));
    checkOutput("reset busy", LB'(busy), LB'(0));
    checkOutput("reset mem_we", LB'(mem_we), LB'(0));
    checkOutput("reset mem_re", LB'(mem_re), LB'(0));
    checkOutput("reset resp_valid", LB'(resp_valid), LB'(0));
    checkOutput("reset mem_addr", LB'(mem_addr), LB'(0));
    checkOutput("reset mem_wdata", LB'(mem_wdata), LB'(0));
    checkOutput("reset resp_data", resp_data, LB'(0));

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset during the second write-back cycle: only word 0 may land in RAM.
    @(negedge clk);
    req_valid     = 1'b1;
    req_wb        = 1'b1;
    req_wb_addr   = 14'h1080;
    req_wb_data   = {32'h4D, 32'h4C, 32'h4B, 32'h4A};
    req_fill_addr = 14'h1000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_mid_wb first write", LB'(mem_we), LB'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wb mem_we", LB'(mem_we), LB'(0));
    checkOutput("rst_mid_wb busy", LB'(busy), LB'(0));
    checkOutput("rst_mid_wb resp_data", resp_data, LB'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_wb req_ready", LB'(req_ready), LB'(1));
    begin
      int activity = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (mem_we || mem_re || resp_valid || busy) activity++;
      end
      checkOutput("rst_mid_wb no_resume", LB'(activity), LB'(0));
    end
    checkOutput("rst_mid_wb word0", LB'(ram[32]), LB'(32'h4A));
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("rst_mid_wb word%0d", i), LB'(ram[32 + i]), LB'(32'hEEEE));

`ifdef REFILL_STATS_EN
    checkOutput("stats after reset fills", LB'(stat_fills), LB'(0));
    checkOutput("stats after reset wbs", LB'(stat_wbs), LB'(0));
    applyStimulus(vecs[0]);
    applyStimulus(vecs[2]);
    applyStimulus(vecs[4]);
    checkOutput("stat_fills", LB'(stat_fills), LB'(3));
    checkOutput("stat_wbs", LB'(stat_wbs), LB'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/cache_refill_unit.md
CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4: 32-bit words per cache line, power of two, range 2..8.
REQ-002 SHALL have parameter BASE_ADDR, default 14'h1000: byte address mapped to memory word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  cache miss request.
REQ-006 SHALL have port req_ready  output  1  unit idle, request accepted this cycle if req_valid.
REQ-007 SHALL have port req_wb  input  1  evicted line needs write-back.
REQ-008 SHALL have port req_wb_addr  input  14  byte address of evicted line.
REQ-009 SHALL have port req_wb_data  input  32*LINE_WORDS  evicted line; word k is bits [32k+31:32k].
REQ-010 SHALL have port req_fill_addr  input  14  byte address inside the line to fetch.
REQ-011 SHALL have port resp_valid  output  1  one-cycle pulse; fill line valid.
REQ-012 SHALL have port resp_data  output  32*LINE_WORDS  fetched line.
REQ-013 SHALL have port mem_addr  output  10  word address to block RAM.
REQ-014 SHALL have port mem_we  output  1  write strobe.
REQ-015 SHALL have port mem_re  output  1  read strobe.
REQ-016 SHALL have port mem_wdata  output  32  write data.
REQ-017 SHALL have port mem_rdata  input  32  read data, valid the cycle after mem_re.
REQ-018 SHALL have port busy  output  1  state != IDLE.

Function
REQ-019 SHALL use states IDLE, WB, RD, LAST, RESP; req_ready = (state == IDLE).
REQ-020 SHALL, on req_valid & req_ready, register all req_* inputs, clear word index k, and go to WB if req_wb else RD.
REQ-021 SHALL form the line word base as ((addr - BASE_ADDR) >> 2) with low log2(LINE_WORDS) bits cleared, truncated to 10 bits; subtraction wraps modulo 2^14.
REQ-022 SHALL, in WB, drive mem_we=1, mem_addr = wb base + k, mem_wdata = word k, for LINE_WORDS consecutive cycles, then enter RD with k=0.
REQ-023 SHALL, in RD, drive mem_re=1, mem_addr = fill base + k for LINE_WORDS cycles, capturing mem_rdata into word k-1 of the line register each cycle after the first, then enter LAST.
REQ-024 SHALL, in LAST, capture the final word into word LINE_WORDS-1 and enter RESP.
REQ-025 SHALL, in RESP, assert resp_valid for exactly one cycle with resp_data stable, then return to IDLE.
REQ-026 SHALL hold resp_data unchanged from RESP until the next request's first capture.
REQ-027 SHALL give latency from accept edge to resp_valid of LINE_WORDS+2 cycles without write-back and 2*LINE_WORDS+2 with it.
REQ-028 SHALL ignore req_valid while not IDLE; no queueing.
REQ-029 SHALL, when write-back and fill lines coincide, return the just-written data (writes strictly precede reads).
REQ-030 SHALL never assert mem_we and mem_re in the same cycle.
REQ-031 SHALL wrap word addresses modulo 1024 without error.

Reset
REQ-032 SHALL, on rst_n low at any time, go to IDLE, clearing mem_we, mem_re, resp_valid, mem_addr, mem_wdata, resp_data, k, and the stat counters to 0.
REQ-033 SHALL, when reset arrives mid-WB, leave the remaining words unwritten; no resume after release.
REQ-034 SHALL assert req_ready in the first cycle after rst_n deasserts.

Configuration
REQ-035 SHALL, with REFILL_STATS_EN defined, add outputs stat_fills[15:0] and stat_wbs[15:0], incremented at each RESP and each WB completion, saturating at 16'hFFFF.
REQ-036 SHALL, without REFILL_STATS_EN, omit those ports and counters entirely.

Structure
REQ-037 SHALL take state encodings, the 14-bit address width, and the 10-bit word address width from a shared package used by the cached data memory.
REQ-038 SHALL be a single module with no sub-modules.

Verification
REQ-039 SHALL cover fill only: LINE_WORDS=4, fill addr 14'h1010, RAM words 4..7 = 0xA..0xD -> mem_re on addrs 4,5,6,7, resp_valid at cycle 6, resp_data = {0xD,0xC,0xB,0xA}.
REQ-040 SHALL cover write-back plus fill: wb addr 14'h1020 with line {4,3,2,1}, fill addr 14'h1000 -> mem_we on addrs 8..11 with data 1..4, then reads of 0..3, resp_valid at cycle 10.
REQ-041 SHALL cover same-line write-back and fill at 14'h1040 with line {0x44,0x33,0x22,0x11} -> resp_data equals the written line.
REQ-042 SHALL cover a second req_valid asserted during WB -> not accepted, req_ready low until after RESP, exactly one resp_valid pulse.
REQ-043 SHALL cover rst_n low at the second WB cycle -> next cycle mem_we=0, busy=0, req_ready=1 after release, and only word 0 written.
REQ-044 SHALL cover, with REFILL_STATS_EN, 3 fills of which 2 have write-back -> stat_fills=3, stat_wbs=2.
